// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: two requesters share one
// registered write port; a pending-write scoreboard feeds hazard checks for issue.
module regfile_wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [4:0]  r0_addr,
  input  logic [31:0] r0_data,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [4:0]  r1_addr,
  input  logic [31:0] r1_data,
  output logic        r1_ready,
  output logic        L_S,
  output logic [4:0]  Wt_addr,
  output logic [31:0] Wt_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  chk_addr_A,
  input  logic [4:0]  chk_addr_B,
  output logic        hazard_A,
  output logic        hazard_B,
  output logic [31:0] pending
);

  // last_grant_r = 1 means r1 won the most recent contended cycle
  logic        last_grant_r;
  logic [31:0] pending_r;
  logic        grant0_s;
  logic        grant1_s;
  logic        contend_s;
  logic        xfer_s;
  logic [4:0]  xfer_addr_s;
  logic [31:0] xfer_data_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;
  logic [31:0] pending_nxt_s;

  assign contend_s = !rst && r0_valid && r1_valid;

  // Grant selection from valids and arbitration history only
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (r0_valid && r1_valid) begin
      if (RR_EN) begin
        grant0_s = last_grant_r;
        grant1_s = !last_grant_r;
      end else begin
        grant0_s = 1'b1;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = r0_valid;
      grant1_s = r1_valid;
    end
  end

  assign r0_ready = grant0_s;
  assign r1_ready = grant1_s;

  assign xfer_s      = (grant0_s && r0_valid) || (grant1_s && r1_valid);
  assign xfer_addr_s = grant1_s ? r1_addr : r0_addr;
  assign xfer_data_s = grant1_s ? r1_data : r0_data;

  // A new reservation is applied after the clear so it wins on a collision
  assign clr_mask_s    = L_S ? (32'd1 << Wt_addr) : 32'd0;
  assign set_mask_s    = (rsv_valid && (rsv_addr != 5'd0)) ? (32'd1 << rsv_addr) : 32'd0;
  assign pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // Write port, scoreboard and arbitration history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      L_S          <= 1'b0;
      Wt_addr      <= 5'd0;
      Wt_data      <= 32'd0;
      pending_r    <= 32'd0;
      last_grant_r <= 1'b1;
    end else begin
      L_S       <= xfer_s && (xfer_addr_s != 5'd0);
      pending_r <= pending_nxt_s;
      if (xfer_s && (xfer_addr_s != 5'd0)) begin
        Wt_addr <= xfer_addr_s;
        Wt_data <= xfer_data_s;
      end
      if (contend_s) begin
        last_grant_r <= grant1_s;
      end
    end
  end

  assign pending  = pending_r;
  assign hazard_A = (chk_addr_A != 5'd0) && pending_r[chk_addr_A];
  assign hazard_B = (chk_addr_B != 5'd0) && pending_r[chk_addr_B];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter; instance 0 is round-robin,
// instance 1 is fixed priority, both checked against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, rsv_valid;
  logic [4:0]  r0_addr, r1_addr, rsv_addr, chk_a, chk_b;
  logic [31:0] r0_data, r1_data;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        ls   [2];
  logic        haz_a[2];
  logic        haz_b[2];
  logic [4:0]  wa   [2];
  logic [31:0] wd   [2];
  logic [31:0] pend [2];

  int total = 0;
  int bad   = 0;

  // reference model state: what the registered outputs should show right now
  int          m_last[2];   // requester that won the last contended cycle
  logic [31:0] m_pend[2];
  logic        m_ls  [2];
  logic [4:0]  m_wa  [2];
  logic [31:0] m_wd  [2];
  bit          m_wok [2];   // Wt_* value is defined by the model

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(rdy0[0]),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(rdy1[0]),
    .L_S(ls[0]), .Wt_addr(wa[0]), .Wt_data(wd[0]),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr_A(chk_a), .chk_addr_B(chk_b),
    .hazard_A(haz_a[0]), .hazard_B(haz_b[0]), .pending(pend[0])
  );

  regfile_wb_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(rdy0[1]),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(rdy1[1]),
    .L_S(ls[1]), .Wt_addr(wa[1]), .Wt_data(wd[1]),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr_A(chk_a), .chk_addr_B(chk_b),
    .hazard_A(haz_a[1]), .hazard_B(haz_b[1]), .pending(pend[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_last[k] = 1;
    m_pend[k] = 32'd0;
    m_ls[k]   = 1'b0;
    m_wa[k]   = 5'd0;
    m_wd[k]   = 32'd0;
    m_wok[k]  = 1'b1;
  endtask

  // check both instances mid-cycle, then advance the model across the next edge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit          e0, e1, rr;
      logic [4:0]  a;
      logic [31:0] d, np;
      rr = (k == 0);
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst) begin
        if (r0_valid && r1_valid) begin
          if (rr && m_last[k] == 0) e1 = 1'b1;
          else e0 = 1'b1;
        end else begin
          e0 = r0_valid;
          e1 = r1_valid;
        end
      end
      check_eq($sformatf("i%0d_r0_ready", k), 32'(rdy0[k]), 32'(e0));
      check_eq($sformatf("i%0d_r1_ready", k), 32'(rdy1[k]), 32'(e1));
      check_eq($sformatf("i%0d_L_S", k), 32'(ls[k]), 32'(m_ls[k]));
      if (m_wok[k]) begin
        check_eq($sformatf("i%0d_Wt_addr", k), 32'(wa[k]), 32'(m_wa[k]));
        check_eq($sformatf("i%0d_Wt_data", k), wd[k], m_wd[k]);
      end
      check_eq($sformatf("i%0d_pending", k), pend[k], m_pend[k]);
      check_eq($sformatf("i%0d_hazard_A", k), 32'(haz_a[k]), 32'((chk_a != 5'd0) && m_pend[k][chk_a]));
      check_eq($sformatf("i%0d_hazard_B", k), 32'(haz_b[k]), 32'((chk_b != 5'd0) && m_pend[k][chk_b]));

      if (rst) begin
        model_reset(k);
      end else begin
        np = m_pend[k];
        if (m_ls[k]) np[m_wa[k]] = 1'b0;
        if (rsv_valid && rsv_addr != 5'd0) np[rsv_addr] = 1'b1;
        m_pend[k] = np;
        if (e0 || e1) begin
          a = e1 ? r1_addr : r0_addr;
          d = e1 ? r1_data : r0_data;
          if (a != 5'd0) begin
            m_ls[k] = 1'b1; m_wa[k] = a; m_wd[k] = d; m_wok[k] = 1'b1;
          end else begin
            m_ls[k] = 1'b0; m_wok[k] = 1'b0;
          end
        end else begin
          m_ls[k] = 1'b0;
        end
        if (r0_valid && r1_valid) m_last[k] = e1 ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsv_valid = 1'b0;
    r0_addr = 5'd0; r1_addr = 5'd0; rsv_addr = 5'd0;
    r0_data = 32'd0; r1_data = 32'd0; chk_a = 5'd0; chk_b = 5'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) model_reset(k);
    repeat (2) @(posedge clk);
    #1;
    // reset held with active requests: no grants, state stays cleared
    r0_valid = 1'b1; r1_valid = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd4;
    step();
    idle();
    step();

    // contended burst: round-robin alternates, fixed priority holds r0
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hA;
    r1_valid = 1'b1; r1_addr = 5'd6; r1_data = 32'hB;
    repeat (3) step();
    idle();
    step();
    check_eq("rr_last_wt_addr", 32'(wa[0]), 32'd5);
    check_eq("fp_last_wt_addr", 32'(wa[1]), 32'd5);

    // write to x0 is accepted but never reaches the port
    r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 32'hFFFF_FFFF;
    step();
    idle();
    step();

    // reserve x7, see hazard, retire via r1, hazard drops
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    idle(); chk_a = 5'd7; chk_b = 5'd7;
    step();
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h1234;
    step();
    idle(); chk_a = 5'd7;
    step();
    step();

    // reservation of x9 in the same cycle its write lands wins
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'h99;
    step();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    idle(); chk_b = 5'd9;
    step();

    // reset during an in-flight write cancels it and clears the scoreboard
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    step();
    idle(); r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'h33;
    step();
    idle(); rst = 1'b1; r0_valid = 1'b1; r0_addr = 5'd3; rsv_valid = 1'b1; rsv_addr = 5'd12;
    step();
    idle();
    step();

    // hold check: no transfers leave Wt_* untouched
    r1_valid = 1'b1; r1_addr = 5'd17; r1_data = 32'hCAFE_0017;
    step();
    idle();
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      r0_valid  = $urandom_range(0, 1);
      r1_valid  = $urandom_range(0, 1);
      r0_addr   = 5'($urandom_range(0, 31));
      r1_addr   = 5'($urandom_range(0, 31));
      r0_data   = $urandom;
      r1_data   = $urandom;
      rsv_valid = $urandom_range(0, 1);
      rsv_addr  = 5'($urandom_range(0, 31));
      chk_a     = 5'($urandom_range(0, 31));
      chk_b     = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 winning.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Ports r0_valid / r1_valid, input, 1: requester 0 (ALU writeback) / requester 1 (load writeback) holds a write.
REQ-005 Ports r0_addr / r1_addr, input, 5: destination register index.
REQ-006 Ports r0_data / r1_data, input, 32: write data.
REQ-007 Ports r0_ready / r1_ready, output, 1: grant; a transfer occurs on a cycle where valid and ready are both 1.
REQ-008 Port L_S, output, 1: registered write enable to the register-file write port.
REQ-009 Ports Wt_addr (output, 5) and Wt_data (output, 32): registered write address and data.
REQ-010 Ports rsv_valid (input, 1) and rsv_addr (input, 5): issue stage reserves a destination register as pending.
REQ-011 Ports chk_addr_A / chk_addr_B, input, 5: source registers to hazard-check.
REQ-012 Ports hazard_A / hazard_B, output, 1: combinational; 1 means the source value is not yet written.
REQ-013 Port pending, output, 32: scoreboard mask; bit i is 1 while register i awaits writeback.

Function
REQ-014 Write port accepts one write per cycle and never stalls; a granted requester always transfers when valid.
REQ-015 Only r0 valid: r0_ready=1, r1_ready=0. Only r1 valid: r1_ready=1, r0_ready=0. Neither valid: both readies 0.
REQ-016 Both valid, RR_EN=1: grant the requester not granted in the most recent contended cycle; last_grant register updates only on contended cycles.
REQ-017 Both valid, RR_EN=0: r0 is always granted.
REQ-018 Readies are combinational from valids and last_grant; they never depend on data or address.
REQ-019 A transfer at cycle N drives L_S=1 with that Wt_addr/Wt_data at cycle N+1 (latency 1, registered).
REQ-020 No transfer at cycle N: L_S=0 at N+1; Wt_addr and Wt_data hold their previous values.
REQ-021 A transfer with addr=0 is accepted (ready=1) but produces L_S=0; x0 is never written.
REQ-022 rsv_valid=1 with rsv_addr!=0 sets pending[rsv_addr] at the next edge; rsv_addr=0 is ignored; pending[0] is always 0.
REQ-023 Cycle with L_S=1 clears pending[Wt_addr] at the next edge.
REQ-024 A set and a clear of the same index on the same edge leave the bit set (new reservation wins).
REQ-025 hazard_X = (chk_addr_X!=0) and pending[chk_addr_X], where X is A or B.
REQ-026 A write at cycle N has its pending bit clear at N+1; L_S/Wt_* at N+1 reach the register file, so no bypass is required.
REQ-027 Duplicate reservation of a pending index keeps the bit at 1; a single write clears it (no counting).

Reset
REQ-028 When rst=1 at an edge: L_S=0, Wt_addr=0, Wt_data=0, pending=0, last_grant=1 (so r0 wins the first contended cycle).
REQ-029 While rst=1, r0_ready and r1_ready are 0, and reservations and transfers are ignored.
REQ-030 rst=1 during an in-flight write (L_S=1) cancels it: L_S=0 on the following cycle, and pending is cleared regardless of simultaneous set/clear.

Verification
REQ-031 After reset, r0 and r1 both valid for 3 cycles (addrs 5/6, data 0xA/0xB), RR_EN=1 -> grants r0, r1, r0; L_S=1 with Wt_addr 5, 6, 5 one cycle later.
REQ-032 RR_EN=0, both valid for 3 cycles -> r0_ready=1 every cycle, r1_ready=0 every cycle.
REQ-033 r0 write to addr 0 with data 0xFFFFFFFF -> r0_ready=1, next cycle L_S=0.
REQ-034 rsv addr 7, then chk_addr_A=7 -> hazard_A=1; r1 write to addr 7 (data 0x1234) -> L_S=1, Wt_addr=7 one cycle later; hazard_A=0 the cycle after that.
REQ-035 In the cycle L_S=1 with Wt_addr=9, assert rsv_valid with rsv_addr=9 -> pending[9]=1 afterwards.
REQ-036 Reserve addr 3, then assert rst in the cycle an r0 transfer occurs -> next cycle L_S=0 and pending=0.
